// File: rtl/nco_iq_sequencer.sv
// NCO controller: owns phase/FCW and time-multiplexes one SineLut to produce
// a cosine (I) / sine (Q) pair per phase step on a valid/ready interface.
module nco_iq_sequencer #(
    parameter int unsigned PHASE_BITS  = 32,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned DW          = 16,
    parameter int unsigned LUT_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic        [PHASE_BITS-1:0] fcw_i,
    input  logic                         fcw_load_i,
    input  logic                         phase_clr_i,
    output logic        [ADDR_BITS-1:0]  lut_addr_o,
    input  logic signed [DW-1:0]         lut_sample_i,
    output logic signed [DW-1:0]         i_o,
    output logic signed [DW-1:0]         q_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         busy_o
);

    localparam int unsigned CNT_W = (LUT_LATENCY < 2) ? 1 : $clog2(LUT_LATENCY + 1);
    localparam logic [CNT_W-1:0]     LAT_LAST = CNT_W'(LUT_LATENCY);
    localparam logic [CNT_W-1:0]     LAT_I    = CNT_W'(LUT_LATENCY - 1);
    localparam logic [ADDR_BITS-1:0] QUARTER  = ADDR_BITS'(2 ** (ADDR_BITS - 2));

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE_COS = 3'd1,
        S_ISSUE_SIN = 3'd2,
        S_WAIT      = 3'd3,
        S_HOLD      = 3'd4
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [PHASE_BITS-1:0] phase_q;
    logic [PHASE_BITS-1:0] fcw_q;
    logic [ADDR_BITS-1:0]  sin_addr_q;
    logic [CNT_W-1:0]      lat_cnt_q;
    logic [ADDR_BITS-1:0]  base;
    logic [ADDR_BITS-1:0]  cos_addr;

    logic issue_cos_c;
    logic issue_sin_c;
    logic cap_i_c;
    logic cap_q_c;
    logic cnt_inc_c;
    logic advance_c;
    logic valid_d;
    logic busy_d;

    assign base     = phase_q[PHASE_BITS-1 -: ADDR_BITS];
    assign cos_addr = base + QUARTER;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (en_i) state_d = S_ISSUE_COS;
            S_ISSUE_COS: state_d = S_ISSUE_SIN;
            S_ISSUE_SIN: state_d = S_WAIT;
            S_WAIT:      if (lat_cnt_q == LAT_LAST) state_d = S_HOLD;
            S_HOLD:      if (ready_i) state_d = en_i ? S_ISSUE_COS : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Control strobes; i/q capture points are counted from each address issue
    always_comb begin
        issue_cos_c = 1'b0;
        issue_sin_c = 1'b0;
        cap_i_c     = 1'b0;
        cap_q_c     = 1'b0;
        cnt_inc_c   = 1'b0;
        advance_c   = 1'b0;
        valid_d     = valid_o;
        busy_d      = (state_d == S_ISSUE_COS) || (state_d == S_ISSUE_SIN) ||
                      (state_d == S_WAIT);
        case (state_q)
            S_ISSUE_COS: issue_cos_c = 1'b1;
            S_ISSUE_SIN: begin
                issue_sin_c = 1'b1;
                if (LUT_LATENCY == 1) cap_i_c = 1'b1;
            end
            S_WAIT: begin
                if ((LUT_LATENCY > 1) && (lat_cnt_q == LAT_I)) cap_i_c = 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    cap_q_c = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            S_HOLD: begin
                if (ready_i) begin
                    advance_c = 1'b1;
                    valid_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath; sine address is latched with the cosine so a mid-pair clear cannot split the pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q    <= '0;
            fcw_q      <= '0;
            sin_addr_q <= '0;
            lat_cnt_q  <= '0;
            lut_addr_o <= '0;
            i_o        <= '0;
            q_o        <= '0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            if (fcw_load_i) fcw_q <= fcw_i;
            if (phase_clr_i) begin
                phase_q <= '0;
            end else if (advance_c) begin
                phase_q <= phase_q + fcw_q;
            end
            if (issue_cos_c) begin
                lut_addr_o <= cos_addr;
                sin_addr_q <= base;
            end
            if (issue_sin_c) begin
                lut_addr_o <= sin_addr_q;
                lat_cnt_q  <= CNT_W'(1);
            end else if (cnt_inc_c) begin
                lat_cnt_q  <= lat_cnt_q + CNT_W'(1);
            end
            if (cap_i_c) i_o <= lut_sample_i;
            if (cap_q_c) q_o <= lut_sample_i;
            valid_o <= valid_d;
            busy_o  <= busy_d;
        end
    end

endmodule

// File: tb/tb_nco_iq_sequencer.sv
// Scoreboard bench: two sequencers (LUT latency 1 and 3) share stimulus and are
// checked against a transaction-level phase model with trigonometric references.
module tb_nco_iq_sequencer;

    localparam real PI  = 3.141592653589793;
    localparam real AMP = 32767.0;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, fcw_load, phase_clr, ready;
    logic [31:0] fcw;
    logic [9:0]  addr1, addr3, d1, d2;
    logic signed [15:0] samp1, samp3, i1, q1, i3, q3;
    logic        valid1, valid3, busy1, busy3;
    logic signed [15:0] tab [1024];

    int    n_tests = 0;
    int    n_fail  = 0;
    pair_t exp_q [2][$];
    int    n_pairs [2];
    bit    chk_period = 1'b0;

    nco_iq_sequencer #(.PHASE_BITS(32), .ADDR_BITS(10), .DW(16), .LUT_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .en_i(en), .fcw_i(fcw), .fcw_load_i(fcw_load),
        .phase_clr_i(phase_clr), .lut_addr_o(addr1), .lut_sample_i(samp1),
        .i_o(i1), .q_o(q1), .valid_o(valid1), .ready_i(ready), .busy_o(busy1)
    );

    nco_iq_sequencer #(.PHASE_BITS(32), .ADDR_BITS(10), .DW(16), .LUT_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .en_i(en), .fcw_i(fcw), .fcw_load_i(fcw_load),
        .phase_clr_i(phase_clr), .lut_addr_o(addr3), .lut_sample_i(samp3),
        .i_o(i3), .q_o(q3), .valid_o(valid3), .ready_i(ready), .busy_o(busy3)
    );

    // LUT models: latency 1 is a direct read, latency 3 adds two register stages
    assign samp1 = tab[addr1];
    assign samp3 = tab[d2];
    always @(posedge clk) begin
        d1 <= addr3;
        d2 <= d1;
    end

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic pair_t ref_pair(input logic [31:0] ph);
        pair_t p;
        real   th;
        th  = 2.0 * PI * real'(int'(ph[31:22])) / 1024.0;
        p.i = 16'(rnd(AMP * $cos(th)));
        p.q = 16'(rnd(AMP * $sin(th)));
        return p;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase/fcw per transaction; a pair starts whenever the
    // sequencer is free and enabled, and takes the phase current at that point.
    logic [31:0] ph_m  [2];
    logic [31:0] fcw_m [2];
    bit          in_pair [2];
    bit          vprev   [2];

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            bit hs;
            if (!rst) begin
                ph_m[k] = '0; fcw_m[k] = '0; in_pair[k] = 1'b0; vprev[k] = 1'b0;
                exp_q[k].delete();
            end else begin
                hs = vprev[k] && ready;
                if (phase_clr)  ph_m[k] = '0;
                else if (hs)    ph_m[k] = ph_m[k] + fcw_m[k];
                if (fcw_load)   fcw_m[k] = fcw;
                if (hs)         in_pair[k] = 1'b0;
                if (!in_pair[k] && en) begin
                    exp_q[k].push_back(ref_pair(ph_m[k]));
                    in_pair[k] = 1'b1;
                end
                vprev[k] = (k == 0) ? valid1 : valid3;
            end
        end
    end

    // Monitor: compares each newly presented pair and optionally its spacing
    bit vseen [2];
    int last_rise [2] = '{-1, -1};
    int cyc = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            bit    vnow;
            pair_t act, e;
            vnow  = (k == 0) ? valid1 : valid3;
            act.i = (k == 0) ? i1 : i3;
            act.q = (k == 0) ? q1 : q3;
            if (vnow && !vseen[k]) begin
                n_pairs[k]++;
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("dut%0d_unexpected_pair", k), 1, 0);
                end else begin
                    e = exp_q[k].pop_front();
                    chk($sformatf("dut%0d_pair_i", k), longint'(act.i), longint'(e.i));
                    chk($sformatf("dut%0d_pair_q", k), longint'(act.q), longint'(e.q));
                end
                if (chk_period && last_rise[k] >= 0)
                    chk($sformatf("dut%0d_period", k), cyc - last_rise[k], (k == 0) ? 4 : 6);
                last_rise[k] = chk_period ? cyc : -1;
            end
            vseen[k] = vnow;
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_addr1"}, addr1, 0);   chk({name, "_addr3"}, addr3, 0);
        chk({name, "_i1"}, i1, 0);         chk({name, "_i3"}, i3, 0);
        chk({name, "_q1"}, q1, 0);         chk({name, "_q3"}, q3, 0);
        chk({name, "_valid1"}, valid1, 0); chk({name, "_valid3"}, valid3, 0);
        chk({name, "_busy1"}, busy1, 0);   chk({name, "_busy3"}, busy3, 0);
    endtask

    task automatic idle_quiet(input string name);
        bit seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid1 || valid3 || busy1 || busy3) seen = 1'b1;
        end
        chk({name, "_idle_quiet"}, seen, 0);
    endtask

    task automatic wait_valid1(input string name);
        bit found = valid1;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            found = valid1;
        end
        chk({name, "_valid_seen"}, found, 1);
    endtask

    // Returns at the negedge of dut1's ISSUE_COS cycle (first busy cycle)
    task automatic wait_busy_rise(input string name);
        bit prev  = busy1;
        bit found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            if (busy1 && !prev) found = 1'b1;
            prev = busy1;
        end
        chk({name, "_busy_rise"}, found, 1);
    endtask

    initial begin
        logic signed [15:0] hi, hq;
        logic [9:0]         ha;
        for (int a = 0; a < 1024; a++)
            tab[a] = 16'(rnd(AMP * $sin(2.0 * PI * real'(a) / 1024.0)));
        rst = 1'b0; en = 1'b0; fcw = '0; fcw_load = 1'b0; phase_clr = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        idle_quiet("post_reset");

        // Quarter-turn stepping
        fcw = 32'h4000_0000; fcw_load = 1'b1;
        @(negedge clk);
        fcw_load = 1'b0; en = 1'b1; chk_period = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 chk("first_cos_addr", addr1, 256);
        @(posedge clk); #1 chk("first_sin_addr", addr1, 0);
        repeat (26) @(negedge clk);
        chk_period = 1'b0;

        // Backpressure
        wait_valid1("bp");
        ready = 1'b0; hi = i1; hq = q1; ha = addr1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", valid1, 1);
            chk("bp_i", i1, hi);
            chk("bp_q", q1, hq);
            chk("bp_addr", addr1, ha);
            chk("bp_busy", busy1, 0);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", valid1, 0);
        chk("bp_release_busy", busy1, 1);

        // FCW load while dut1 is in WAIT
        wait_busy_rise("fcw");
        @(negedge clk); @(negedge clk);
        fcw = 32'h2000_0000; fcw_load = 1'b1;
        @(negedge clk);
        fcw_load = 1'b0;
        repeat (12) @(negedge clk);

        // Phase clear coincident with handshake
        wait_valid1("clr");
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        @(posedge clk); #1 chk("clr_cos_addr", addr1, 256);
        @(posedge clk); #1 chk("clr_sin_addr", addr1, 0);

        // Randomized traffic
        repeat (400) begin
            @(negedge clk);
            en        = ($urandom_range(0, 9) != 0);
            ready     = ($urandom_range(0, 9) < 7);
            fcw_load  = ($urandom_range(0, 19) == 0);
            fcw       = $urandom;
            phase_clr = ($urandom_range(0, 29) == 0);
        end
        @(negedge clk);
        en = 1'b1; ready = 1'b1; fcw_load = 1'b0; phase_clr = 1'b0;

        // Enable dropped in ISSUE_SIN
        wait_busy_rise("endrop");
        @(negedge clk);
        en = 1'b0; ready = 1'b0;
        wait_valid1("endrop");
        repeat (5) begin
            @(negedge clk);
            chk("endrop_hold_valid", valid1, 1);
        end
        ready = 1'b1;
        @(negedge clk);
        chk("endrop_accept", valid1, 0);
        repeat (10) begin
            @(negedge clk);
            chk("endrop_idle_busy1", busy1, 0);
            chk("endrop_idle_valid1", valid1, 0);
        end
        chk("endrop_idle_busy3", busy3, 0);
        chk("endrop_idle_valid3", valid3, 0);

        // Asynchronous reset in the middle of WAIT
        en = 1'b1;
        wait_busy_rise("rstmid");
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("rst_mid");
        en = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        idle_quiet("rst_mid");

        chk("sb_empty", exp_q[0].size() + exp_q[1].size(), 0);
        chk("dut1_pairs_checked", n_pairs[0] >= 20, 1);
        chk("dut3_pairs_checked", n_pairs[1] >= 10, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
